sfifo_param: RTL and testbench

- Single-clock, parametrised FIFO that succeeds the dual-clock FIFO block. It keeps the winc/wdata/wfull and rinc/rdata/rempty port semantics.
- It adds:
  - generic depth
  - programmable almost-full/almost-empty levels
  - an occupancy count
  - sticky overflow/underflow error flags
  - a first-word-fall-through (FWFT) mode
- It is used wherever producer and consumer share a clock, such as staging buffers in front of the async FIFO and test harness loopbacks.

---
 rtl/sfifo_param.sv | 159 +++++++++++++++
 tb/tb_sfifo_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sfifo_param.sv
// ---------------------------------------------------------------------------
// sfifo_param -- single-clock parametrised FIFO.
//
// Successor to the dual-clock FIFO for producer/consumer pairs that share a
// clock. It keeps the winc/wdata/wfull and rinc/rdata/rempty semantics and
// adds the following:
//   - a generic depth
//   - almost-full and almost-empty levels
//   - an occupancy count
//   - sticky overflow and underflow flags
//   - an optional first-word-fall-through read port
//
// Parameters:
//   DATA_WIDTH  width of wdata/rdata
//   ADDR_WIDTH  pointer address bits, DEPTH = 2**ADDR_WIDTH
//   AFULL_LVL   walmost_full when count >= AFULL_LVL
//   AEMPTY_LVL  ralmost_empty when count <= AEMPTY_LVL
//   FWFT        0: registered read, 1-cycle latency; 1: head word shown
//               combinationally while not empty
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   winc, wdata    write request and data; accepted when !wfull
//   wfull          count == DEPTH
//   walmost_full   count >= AFULL_LVL
//   rinc           read request; accepted when !rempty
//   rdata          read data (registered or fall-through, see FWFT)
//   rempty         count == 0
//   ralmost_empty  count <= AEMPTY_LVL
//   count          occupancy, 0..DEPTH
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
//   err_clr        clears overflow/underflow (a same-cycle error wins)
// ---------------------------------------------------------------------------
module sfifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit above the memory index.
    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                wr_en;
    logic                rd_en;

    // Acceptance is gated by the registered flags, so at the full boundary a
    // simultaneous read still drains a word while the write is refused, and
    // at the empty boundary the write lands while the read is refused.
    assign wr_en = winc && !wfull;
    assign rd_en = rinc && !rempty;

    // NOTE: every branch assigns count_nxt after a default, so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + ONE_C;
        end else if (rd_en && !wr_en) begin
            count_nxt = count - ONE_C;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
        end else begin
            if (wr_en) wptr <= wptr + ONE_C;
            if (rd_en) rptr <= rptr + ONE_C;
            count         <= count_nxt;
            // Flags are decoded from the next-state count so they line up
            // with count in the cycle after the causing edge.
            wfull         <= (count_nxt == DEPTH_C);
            walmost_full  <= (count_nxt >= AFULL_C);
            rempty        <= (count_nxt == '0);
            ralmost_empty <= (count_nxt <= AEMPTY_C);
        end
    end

    // Sticky error flags: a new error event takes priority over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)  overflow <= 1'b1;
            else if (err_clr)   overflow <= 1'b0;
            if (rinc && rempty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // The wrapping pointer difference must always equal the tracked count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((wptr - rptr) == count);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word falls through; value is don't-care while empty.
            assign rdata = rempty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= mem[rptr[ADDR_WIDTH-1:0]];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sfifo_param.sv
// ---------------------------------------------------------------------------
// tb_sfifo_param -- self-checking bench for sfifo_param.
// dut0 runs with default parameters (registered read) against a queue-based
// scoreboard. dut1 runs with FWFT=1 for the fall-through latency checks.
// ---------------------------------------------------------------------------
module tb_sfifo_param;

    logic       clk;
    // dut0 (FWFT = 0)
    logic       rst, winc, rinc, err_clr;
    logic [7:0] wdata, rdata;
    logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [4:0] count;
    // dut1 (FWFT = 1)
    logic       f_rst, f_winc, f_rinc, f_err_clr;
    logic [7:0] f_wdata, f_rdata;
    logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard model for dut0
    logic [7:0] sb_q[$];
    int         m_count = 0;
    logic       m_ov = 1'b0;
    logic       m_uf = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    sfifo_param dut0 (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
        .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    sfifo_param #(.FWFT(1)) dut1 (
        .clk(clk), .rst(f_rst), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull),
        .walmost_full(f_walmost_full), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty),
        .ralmost_empty(f_ralmost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .err_clr(f_err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // One clock of dut0: drive at the falling edge, update the scoreboard at
    // the rising edge, compare every output at the next falling edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic c, input logic rs);
        logic wa, ra;
        winc = w; wdata = d; rinc = r; err_clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            sb_q.delete();
            m_ov    = 1'b0;
            m_uf    = 1'b0;
            m_rdata = 8'h00;
        end else begin
            wa = w && (m_count != 16);
            ra = r && (m_count != 0);
            if (w && m_count == 16) m_ov = 1'b1;
            else if (c)             m_ov = 1'b0;
            if (r && m_count == 0)  m_uf = 1'b1;
            else if (c)             m_uf = 1'b0;
            if (ra) m_rdata = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
        end
        m_count = sb_q.size();
        @(negedge clk);
        check("count",         32'(count),         32'(m_count));
        check("wfull",         32'(wfull),         32'(m_count == 16));
        check("walmost_full",  32'(walmost_full),  32'(m_count >= 12));
        check("rempty",        32'(rempty),        32'(m_count == 0));
        check("ralmost_empty", 32'(ralmost_empty), 32'(m_count <= 4));
        check("overflow",      32'(overflow),      32'(m_ov));
        check("underflow",     32'(underflow),     32'(m_uf));
        check("rdata",         32'(rdata),         32'(m_rdata));
    endtask

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        f_rst = 1'b1; f_winc = 1'b0; f_rinc = 1'b0; f_err_clr = 1'b0; f_wdata = 8'h00;

        // Reset for two cycles.
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_count",  32'(count),  32'd0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 10) check("afull_before_12th", 32'(walmost_full), 32'd0);
            if (i == 11) check("afull_after_12th",  32'(walmost_full), 32'd1);
        end
        check("fill_wfull", 32'(wfull), 32'd1);
        check("fill_count", 32'(count), 32'd16);

        // 17th write is rejected and sets overflow.
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);

        // Drain; data follows each rinc edge by one cycle.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 11) check("aempty_at_4", 32'(ralmost_empty), 32'd1);
        end
        check("drain_last", 32'(rdata), 32'h0F);
        check("drain_empty", 32'(rempty), 32'd1);

        // 17th read sets underflow, then clear both.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("udf_set", 32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("err_clr_ovf", 32'(overflow), 32'd0);

        // Simultaneous winc+rinc at full.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        check("full_both_count", 32'(count),    32'd15);
        check("full_both_ovf",   32'(overflow), 32'd1);
        check("full_both_rdata", 32'(rdata),    32'h40);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Simultaneous winc+rinc at empty.
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        check("empty_both_count", 32'(count),     32'd1);
        check("empty_both_udf",   32'(underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clr_ovf", 32'(overflow),  32'd0);
        check("clr_udf", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("empty_both_data", 32'(rdata), 32'h5A);

        // Streaming across many wraps at a steady count of 8.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(8'h88 + i), 1'b1, 1'b0, 1'b0);
        check("stream_count", 32'(count), 32'd8);

        // Reset at count 9 with a write pending.
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd9);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        check("mid_rst_count",  32'(count),     32'd0);
        check("mid_rst_rempty", 32'(rempty),    32'd1);
        check("mid_rst_wfull",  32'(wfull),     32'd0);
        check("mid_rst_ovf",    32'(overflow),  32'd0);
        check("mid_rst_udf",    32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_rst_discard", 32'(count), 32'd0);

        // FWFT = 1 instance.
        @(negedge clk);
        f_rst = 1'b0;
        check("fwft_rst_empty", 32'(f_rempty), 32'd1);
        f_winc = 1'b1; f_wdata = 8'hA5;
        @(posedge clk); @(negedge clk);
        f_winc = 1'b0;
        check("fwft_rdata",  32'(f_rdata),  32'hA5);
        check("fwft_rempty", 32'(f_rempty), 32'd0);
        f_rinc = 1'b1;
        @(posedge clk); @(negedge clk);
        f_rinc = 1'b0;
        check("fwft_drained", 32'(f_rempty), 32'd1);
        check("fwft_count",   32'(f_count),  32'd0);
        f_winc = 1'b1; f_wdata = 8'h3C;
        @(posedge clk); @(negedge clk);
        f_wdata = 8'hC7;
        @(posedge clk); @(negedge clk);
        f_winc = 1'b0;
        check("fwft_head0", 32'(f_rdata), 32'h3C);
        f_rinc = 1'b1;
        @(posedge clk); @(negedge clk);
        f_rinc = 1'b0;
        check("fwft_head1", 32'(f_rdata), 32'hC7);
        check("fwft_cnt1",  32'(f_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
